// File: rtl/note_highway_pkg.sv
// rtl/note_highway_pkg.sv - shared constants and arithmetic helpers for the note highway
package note_highway_pkg;

    localparam int DEF_NUM_LANES = 5;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_HIT_ROWS  = 2;
    localparam int DEF_CNT_W     = 16;

    localparam int STREAK_X2 = 10;
    localparam int STREAK_X3 = 20;
    localparam int STREAK_X4 = 30;

    function automatic logic [31:0] popcount(input logic [31:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    // Never wraps: result clamps at max.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, max}) begin
            return max;
        end
        return s[31:0];
    endfunction

    function automatic logic [2:0] multiplier_for(input logic [31:0] streak);
        if (streak >= 32'(STREAK_X4)) begin
            return 3'd4;
        end else if (streak >= 32'(STREAK_X3)) begin
            return 3'd3;
        end else if (streak >= 32'(STREAK_X2)) begin
            return 3'd2;
        end
        return 3'd1;
    endfunction

endpackage

// File: rtl/note_highway_lane.sv
// rtl/note_highway_lane.sv - one lane: shift column, hit-window search/clear, event pulses
module note_lane #(
    parameter int DEPTH    = 8,
    parameter int HIT_ROWS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             note_in,
    input  logic             press,
    output logic [DEPTH-1:0] col,
    output logic             hit_evt,
    output logic             miss_evt,
    output logic             wrong_evt,
    output logic             hit_pulse,
    output logic             miss_pulse,
    output logic             wrong_pulse
);

    logic [DEPTH-1:0] cleared;
    logic [DEPTH-1:0] col_next;
    logic             found;

    // Press acts on pre-shift contents, so a note entering the window now is out of reach.
    always_comb begin
        cleared = col;
        found   = 1'b0;
        for (int r = DEPTH - 1; r >= DEPTH - HIT_ROWS; r--) begin
            if (press && !found && col[r]) begin
                cleared[r] = 1'b0;
                found      = 1'b1;
            end
        end
        hit_evt   = found;
        wrong_evt = press && !found;
        miss_evt  = shift_en && cleared[DEPTH-1];
        col_next  = shift_en ? {cleared[DEPTH-2:0], note_in} : cleared;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            col         <= '0;
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;
            wrong_pulse <= 1'b0;
        end else begin
            col         <= col_next;
            hit_pulse   <= hit_evt;
            miss_pulse  <= miss_evt;
            wrong_pulse <= wrong_evt;
        end
    end

endmodule

// File: rtl/note_highway.sv
// rtl/note_highway.sv - note highway top: lanes, read port, counters; streak via NOTE_HIGHWAY_STREAK_EN
module note_highway
    import note_highway_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int HIT_ROWS  = DEF_HIT_ROWS,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     shift_en,
    input  logic [NUM_LANES-1:0]     notes_in,
    input  logic [NUM_LANES-1:0]     btn_press,
    input  logic [$clog2(DEPTH)-1:0] rd_row,
    output logic [NUM_LANES-1:0]     rd_data,
    output logic [NUM_LANES-1:0]     note_at_bottom,
    output logic [NUM_LANES-1:0]     hit_pulse,
    output logic [NUM_LANES-1:0]     miss_pulse,
    output logic [NUM_LANES-1:0]     wrong_pulse,
    output logic [CNT_W-1:0]         hit_count,
    output logic [CNT_W-1:0]         miss_count,
    output logic [CNT_W-1:0]         streak,
    output logic [2:0]               multiplier
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [NUM_LANES-1:0][DEPTH-1:0] cols;
    logic [NUM_LANES-1:0]            hit_evt;
    logic [NUM_LANES-1:0]            miss_evt;
    logic [NUM_LANES-1:0]            wrong_evt;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        note_lane #(
            .DEPTH    (DEPTH),
            .HIT_ROWS (HIT_ROWS)
        ) u_lane (
            .clk         (clk),
            .reset       (reset),
            .clear       (clear),
            .shift_en    (shift_en),
            .note_in     (notes_in[l]),
            .press       (btn_press[l]),
            .col         (cols[l]),
            .hit_evt     (hit_evt[l]),
            .miss_evt    (miss_evt[l]),
            .wrong_evt   (wrong_evt[l]),
            .hit_pulse   (hit_pulse[l]),
            .miss_pulse  (miss_pulse[l]),
            .wrong_pulse (wrong_pulse[l])
        );
    end

    always_comb begin
        rd_data        = '0;
        note_at_bottom = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            note_at_bottom[l] = cols[l][DEPTH-1];
            if (32'(rd_row) < 32'(DEPTH)) begin
                rd_data[l] = cols[l][rd_row];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            hit_count  <= CNT_W'(sat_add(32'(hit_count), popcount(32'(hit_evt)), CNT_MAX));
            miss_count <= CNT_W'(sat_add(32'(miss_count), popcount(32'(miss_evt)), CNT_MAX));
        end
    end

`ifdef NOTE_HIGHWAY_STREAK_EN
    logic [CNT_W-1:0] streak_next;

    // Any miss or wrong press breaks the streak, even alongside hits on other lanes.
    always_comb begin
        streak_next = CNT_W'(sat_add(32'(streak), popcount(32'(hit_evt)), CNT_MAX));
        if ((|miss_evt) || (|wrong_evt)) begin
            streak_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            streak     <= '0;
            multiplier <= 3'd1;
        end else begin
            streak     <= streak_next;
            multiplier <= multiplier_for(32'(streak_next));
        end
    end
`else
    assign streak     = '0;
    assign multiplier = 3'd1;
`endif

endmodule

// File: tb/tb_note_highway.sv
// tb/tb_note_highway.sv - directed table-driven bench for note_highway (default and small configs)
module tb_note_highway;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Default configuration
    logic       clear0 = 0, shift0 = 0;
    logic [4:0] notes0 = 0, press0 = 0;
    logic [2:0] rrow0 = 0;
    logic [4:0] rdata0, bottom0, hit0, miss0, wrong0;
    logic [15:0] hc0, mc0, streak0;
    logic [2:0] mult0;

    // DEPTH=6, CNT_W=4 configuration
    logic       clear1 = 0, shift1 = 0;
    logic [4:0] notes1 = 0, press1 = 0;
    logic [2:0] rrow1 = 0;
    logic [4:0] rdata1, bottom1, hit1, miss1, wrong1;
    logic [3:0] hc1, mc1, streak1;
    logic [2:0] mult1;

    note_highway dut0 (
        .clk(clk), .reset(reset), .clear(clear0), .shift_en(shift0), .notes_in(notes0),
        .btn_press(press0), .rd_row(rrow0), .rd_data(rdata0), .note_at_bottom(bottom0),
        .hit_pulse(hit0), .miss_pulse(miss0), .wrong_pulse(wrong0), .hit_count(hc0),
        .miss_count(mc0), .streak(streak0), .multiplier(mult0)
    );

    note_highway #(.DEPTH(6), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .clear(clear1), .shift_en(shift1), .notes_in(notes1),
        .btn_press(press1), .rd_row(rrow1), .rd_data(rdata1), .note_at_bottom(bottom1),
        .hit_pulse(hit1), .miss_pulse(miss1), .wrong_pulse(wrong1), .hit_count(hc1),
        .miss_count(mc1), .streak(streak1), .multiplier(mult1)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       sh;
        logic [4:0] notes;
        logic [4:0] press;
        logic [4:0] bottom;
        logic [4:0] hit;
        logic [4:0] miss;
        logic [4:0] wrong;
        int         hc;
        int         mc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic sh, input logic [4:0] notes, input logic [4:0] press,
                       input logic [4:0] bottom, input logic [4:0] hit, input logic [4:0] miss,
                       input logic [4:0] wrong, input int hc, input int mc);
        vec_t v;
        v.sh = sh; v.notes = notes; v.press = press; v.bottom = bottom;
        v.hit = hit; v.miss = miss; v.wrong = wrong; v.hc = hc; v.mc = mc;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int exp_streak;

    initial begin
        step();
        step();
        reset = 1'b0;

        chk("reset_bottom", 32'(bottom0), 32'd0);
        chk("reset_hit", 32'(hit0), 32'd0);
        chk("reset_hc", 32'(hc0), 32'd0);
        chk("reset_mc", 32'(mc0), 32'd0);
        chk("reset_streak", 32'(streak0), 32'd0);
        chk("reset_mult", 32'(mult0), 32'd1);

        // sh notes press | bottom hit miss wrong hc mc
        add(1, 5'b00001, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 5'b00001, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 5'b00001, 0, 0, 1);
        add(1, 5'b00100, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 5'b00100, 0, 5'b00100, 0, 0, 1, 1);
        add(0, 0, 5'b00100, 0, 0, 0, 5'b00100, 1, 1);
        add(1, 5'b00001, 0, 0, 0, 0, 0, 1, 1);
        add(1, 5'b00001, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0, 0, 1, 1);
        add(1, 0, 0, 5'b00001, 0, 0, 0, 1, 1);
        add(1, 0, 5'b00001, 5'b00001, 5'b00001, 0, 0, 2, 1);
        add(1, 0, 0, 0, 0, 5'b00001, 0, 2, 2);

        foreach (tbl[i]) begin
            shift0 = tbl[i].sh;
            notes0 = tbl[i].notes;
            press0 = tbl[i].press;
            step();
            shift0 = 0; notes0 = 0; press0 = 0;
            chk($sformatf("v%0d_bottom", i), 32'(bottom0), 32'(tbl[i].bottom));
            chk($sformatf("v%0d_hit", i), 32'(hit0), 32'(tbl[i].hit));
            chk($sformatf("v%0d_miss", i), 32'(miss0), 32'(tbl[i].miss));
            chk($sformatf("v%0d_wrong", i), 32'(wrong0), 32'(tbl[i].wrong));
            chk($sformatf("v%0d_hc", i), 32'(hc0), 32'(tbl[i].hc));
            chk($sformatf("v%0d_mc", i), 32'(mc0), 32'(tbl[i].mc));
        end

        // Read port: pattern three shifts below row 0
        shift0 = 1; notes0 = 5'b10101;
        step();
        notes0 = 0;
        step(); step(); step();
        shift0 = 0;
        rrow0 = 3'd3; #1;
        chk("rd_row3", 32'(rdata0), 32'h15);
        rrow0 = 3'd2; #1;
        chk("rd_row2", 32'(rdata0), 32'h0);
        shift0 = 1;
        step(); step(); step(); step();
        shift0 = 0;
        chk("bottom_before_clear", 32'(bottom0), 32'h15);

        // Clear together with a shift that would have missed three notes
        clear0 = 1; shift0 = 1;
        step();
        clear0 = 0; shift0 = 0;
        chk("clear_miss", 32'(miss0), 32'd0);
        chk("clear_mc", 32'(mc0), 32'd0);
        chk("clear_hc", 32'(hc0), 32'd0);
        chk("clear_bottom", 32'(bottom0), 32'd0);
        rrow0 = 3'd3; #1;
        chk("clear_rd", 32'(rdata0), 32'd0);

        // Streak: fill lane 0, then ten hit+shift cycles
        shift0 = 1; notes0 = 5'b00001;
        for (int i = 0; i < 8; i++) step();
        for (int i = 0; i < 10; i++) begin
            press0 = 5'b00001;
            step();
            chk($sformatf("sk%0d_hit", i), 32'(hit0), 32'd1);
            chk($sformatf("sk%0d_miss", i), 32'(miss0), 32'd0);
`ifdef NOTE_HIGHWAY_STREAK_EN
            exp_streak = i + 1;
`else
            exp_streak = 0;
`endif
            chk($sformatf("sk%0d_streak", i), 32'(streak0), 32'(exp_streak));
            chk($sformatf("sk%0d_mult", i), 32'(mult0), (exp_streak >= 10) ? 32'd2 : 32'd1);
        end
        shift0 = 0; notes0 = 0;
        press0 = 5'b00011;
        step();
        press0 = 0;
        chk("mix_hit", 32'(hit0), 32'h1);
        chk("mix_wrong", 32'(wrong0), 32'h2);
        chk("mix_hc", 32'(hc0), 32'd11);
        chk("mix_streak", 32'(streak0), 32'd0);
        chk("mix_mult", 32'(mult0), 32'd1);

        // Reset dominates a simultaneous press and shift
        reset = 1; shift0 = 1; press0 = 5'b11111; notes0 = 5'b11111;
        step();
        reset = 0; shift0 = 0; press0 = 0; notes0 = 0;
        chk("rst_dom_hc", 32'(hc0), 32'd0);
        chk("rst_dom_hit", 32'(hit0), 32'd0);
        chk("rst_dom_bottom", 32'(bottom0), 32'd0);

        // DEPTH=6 read port bounds and CNT_W=4 saturation
        rrow1 = 3'd7; #1;
        chk("d6_rd7_empty", 32'(rdata1), 32'd0);
        shift1 = 1; notes1 = 5'b00001;
        for (int i = 0; i < 6; i++) step();
        shift1 = 0;
        rrow1 = 3'd5; #1;
        chk("d6_rd5", 32'(rdata1), 32'd1);
        rrow1 = 3'd7; #1;
        chk("d6_rd7", 32'(rdata1), 32'd0);
        rrow1 = 3'd6; #1;
        chk("d6_rd6", 32'(rdata1), 32'd0);
        shift1 = 1;
        for (int i = 0; i < 20; i++) begin
            press1 = 5'b00001;
            step();
            chk($sformatf("sat%0d_hit", i), 32'(hit1), 32'd1);
            chk($sformatf("sat%0d_hc", i), 32'(hc1), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end
        press1 = 0; shift1 = 0; notes1 = 0;
        chk("sat_final_hc", 32'(hc1), 32'd15);
        chk("sat_final_mc", 32'(mc1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_highway.md
Name: note_highway

Overview:
- Parametrised note storage for the gameplay screen: NUM_LANES lanes, each a DEPTH-row shift column.
- Notes enter at row 0 (top) and drop one row per shift_en.
- Adds player hit detection in a bottom hit window, per-lane hit/miss/wrong-press pulses and saturating score counters.
- Sits between the song-chart FSM (note source, shift timing), the VGA renderer (row read port) and the score display.

Parameters:
- NUM_LANES, 5, number of note lanes (colours); bit l of every lane vector refers to lane l.
- DEPTH, 8, rows per lane; row 0 top, row DEPTH-1 bottom; DEPTH >= 2.
- HIT_ROWS, 2, rows at the bottom forming the hit window (rows DEPTH-HIT_ROWS..DEPTH-1); 1 <= HIT_ROWS <= DEPTH.
- CNT_W, 16, width of hit/miss/streak counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous song restart; same effect as reset
- shift_en  in  1  drop all lanes one row this cycle
- notes_in  in  NUM_LANES  notes loaded into row 0 on shift_en
- btn_press  in  NUM_LANES  one-cycle press strobes; edge detection is done upstream
- rd_row  in  $clog2(DEPTH)  row selected for the renderer
- rd_data  out  NUM_LANES  combinational contents of row rd_row
- note_at_bottom  out  NUM_LANES  combinational contents of row DEPTH-1
- hit_pulse  out  NUM_LANES  registered, one cycle per successful hit
- miss_pulse  out  NUM_LANES  registered, one cycle per unhit note shifted out
- wrong_pulse  out  NUM_LANES  registered, one cycle per press with empty window
- hit_count  out  CNT_W  total hits, saturating
- miss_count  out  CNT_W  total missed notes, saturating; wrong presses excluded
- streak  out  CNT_W  consecutive hits (feature-dependent)
- multiplier  out  3  score multiplier 1..4 (feature-dependent)

Behaviour:
- Reset or clear: all storage 0, all pulses 0, counts 0, streak 0, multiplier 1. Reset dominates every other input in the same cycle. Mid-song clear aborts silently, with no miss pulses for discarded notes.
- Shift: on shift_en, row r <= row r-1 for r = DEPTH-1..1, and row 0 <= notes_in. A 1 leaving row DEPTH-1 raises miss_pulse[l] on the next cycle.
- Press on lane l, evaluated against pre-shift contents:
  - If any 1 lies in the hit window, clear the one with the highest row index (closest to bottom) and pulse hit_pulse[l] next cycle.
  - Otherwise pulse wrong_pulse[l] next cycle.
- Press and shift in the same cycle: clear first, then shift. A note cleared at row DEPTH-1 is not counted as a miss. A note that moves into the window this cycle cannot be hit this cycle.
- Pulses are all 1-cycle latency from the causing edge. Lanes are independent. Multiple lanes may pulse in the same cycle.
- Counters update in the same cycle as the pulses:
  - hit_count += popcount(hit events); miss_count += popcount(miss events).
  - Both saturate at 2^CNT_W-1 and never wrap.
- Read port: rd_data = row rd_row. rd_row >= DEPTH returns all zeros.
- Without shift_en, storage holds except for press-driven clears.

Optional Feature:
- Macro NOTE_HIGHWAY_STREAK_EN.
- Defined:
  - streak += popcount(hits), saturating.
  - Any miss or wrong event in the same cycle forces streak to 0 (zeroing dominates increment).
  - multiplier, registered from the updated streak: 1 for 0-9, 2 for 10-19, 3 for 20-29, 4 for >=30.
- Undefined: streak tied to 0, multiplier tied to 1, no streak logic synthesised. Ports remain present.

Decomposition:
- note_highway_pkg holds:
  - default parameter constants
  - streak threshold constants (10/20/30)
  - popcount function
  - saturating-add function
- Sub-module note_lane is one lane: shift column, window search/clear, pulse registers. It is instantiated NUM_LANES times via generate.
- Counters and streak logic stay in the top level.

Test Plan:
1. Defaults. notes_in=5'b00001, one shift_en, then 7 more shifts with notes_in=0 -> note_at_bottom=5'b00001 after the 8th. The 9th shift gives miss_pulse=5'b00001 one cycle later and miss_count=1.
2. Note in lane 2 at row 6, press lane 2 -> hit_pulse[2]=1 next cycle, row 6 cleared, hit_count=1. Pressing lane 2 again -> wrong_pulse[2]=1, counts unchanged.
3. Lane 0 holds notes at rows 6 and 7. Press plus shift_en in the same cycle -> row 7 note hit, row 6 note moves to 7, no miss_pulse.
4. rd_row=3 after loading 5'b10101 three shifts earlier -> rd_data=5'b10101. With DEPTH=6, rd_row=7 -> rd_data=0.
5. hit_count preset near max (CNT_W=4), 20 single hits -> hit_count holds at 15.
6. NOTE_HIGHWAY_STREAK_EN: 10 hits -> streak=10, multiplier=2. Then a hit on lane 0 with a wrong press on lane 1 in the same cycle -> streak=0, multiplier=1.
